fib_bcd_converter: RTL and testbench
====================================

// Module: fib_bcd_converter
// PURPOSE
//   Downstream stage of the Fibonacci series generator. Takes each 8-bit term and
//   converts it to packed BCD with an iterative double-dabble (shift-add-3) engine.
//   Drives the decimal display / console path.
//   Uses a valid/ready handshake on both sides, so the generator can be stalled or strobed.
// PARAMETERS
//   DATA_W   8   binary input width; also the number of shift iterations
//   DIGITS   3   BCD output digits; must satisfy 10**DIGITS > 2**DATA_W - 1
// PORTS
//   clk        in   1          single clock; all state updates on the rising edge
//   restart    in   1          synchronous, active-high reset
//   in_valid   in   1          in_data holds a term to convert
//   in_ready   out  1          converter can accept a term (IDLE only)
//   in_data    in   DATA_W     binary term from the generator
//   out_valid  out  1          bcd_out holds a finished result
//   out_ready  in   1          consumer takes the result
//   bcd_out    out  4*DIGITS   packed BCD, most significant digit in the top nibble
//   busy       out  1          high in SHIFT or DONE
//   wrap       out  1          sequence-wrap flag, qualified by out_valid (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (restart=1 at an edge): state=IDLE, in_ready=1, out_valid=0, busy=0,
//     bcd_out=0, wrap=0, iteration count=0, previous-term register=0.
//     restart takes priority over every other event.
//   - FSM states IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: in_ready=1. An edge with in_valid=1 latches in_data into the shift
//     register, clears the BCD register and count, then goes to SHIFT.
//   - SHIFT: in_ready=0. Each edge:
//       1) every BCD nibble >= 5 gets +3;
//       2) {bcd, shift} shifts left by one, the shift-register MSB enters the BCD LSB;
//       3) count increments.
//     The DATA_W-th shift edge moves the FSM to DONE.
//   - Latency: out_valid rises on the DATA_W-th rising edge after the accepting edge.
//   - DONE: out_valid=1. bcd_out and wrap stay stable while out_ready=0 (no limit on
//     stall length). The edge with out_valid && out_ready returns the FSM to IDLE.
//   - No overlap: in_ready=0 throughout SHIFT and DONE, so a new term cannot be taken
//     in the handoff cycle. Peak throughput is one term per DATA_W+2 cycles.
//   - Arithmetic is unsigned. Add-3 works per 4-bit nibble with no carry between nibbles.
//     The DIGITS constraint guarantees no BCD overflow.
//   - restart during SHIFT or DONE drops the in-flight term; out_valid=0 on the next cycle.
//   - in_data may change freely while in_ready=0; it is sampled only at acceptance.
// CONFIGURATION
//   Macro FIB_BCD_WRAP_DETECT_EN:
//   - Defined: keeps the previously accepted term (reset value 0). At acceptance,
//     wrap <= (in_data < prev), then prev <= in_data. wrap is held with bcd_out through DONE.
//     This flags modular wrap of the 8-bit Fibonacci sequence (233 followed by 121).
//   - Undefined: no prev register; wrap is constant 0. The port list is identical
//     in both builds.
// STRUCTURE
//   - Shared package fib_pkg:
//       FIB_DATA_W=8, FIB_BCD_DIGITS=3;
//       state encoding ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
//       typedef for the packed BCD word.
//   - Sub-module fib_bcd_digit_adj: combinational 4-bit nibble, out = (in>=5) ? in+3 : in.
//     Instantiated DIGITS times in a generate loop.
//   - Top module holds the FSM, count, shift/BCD registers, handshake and wrap logic.
// TESTING
//   1) restart held 3 cycles, then released -> in_ready=1, out_valid=0, bcd_out=12'h000.
//   2) in_data=233, in_valid pulse, out_ready=1 -> out_valid on the 8th edge after
//      acceptance, bcd_out=12'h233, single-cycle out_valid.
//   3) Boundary values 0 and 255 -> bcd_out 12'h000 and 12'h255.
//   4) Backpressure: in_data=144, out_ready=0 for 5 cycles after out_valid ->
//      bcd_out=12'h144 stable, in_ready=0; out_ready=1 -> IDLE the next cycle.
//   5) restart asserted on the 4th SHIFT cycle -> next cycle out_valid=0, in_ready=1,
//      bcd_out=0; then in_data=13 converts to 12'h013.
//   6) Feed the generator sequence 0,1,1,...,144,233,121:
//      - with FIB_BCD_WRAP_DETECT_EN, wrap=1 only on 121;
//      - without it, wrap=0 throughout.
//      In both builds every bcd_out matches the decimal value.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci BCD display path.
// Holds the default widths, the converter state encoding and the packed BCD word type.
package fib_pkg;

  localparam int FIB_DATA_W     = 8;
  localparam int FIB_BCD_DIGITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } fib_state_e;

  typedef logic [4*FIB_BCD_DIGITS-1:0] fib_bcd_t;

endpackage : fib_pkg

// File: rtl/fib_bcd_digit_adj.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module fib_bcd_digit_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Add-3 correction stays inside the nibble; no carry leaves it for valid BCD input.
  always_comb begin
    nib_o = nib_i;
    if (nib_i >= 4'd5) begin
      nib_o = nib_i + 4'd3;
    end
  end

endmodule : fib_bcd_digit_adj

// File: rtl/fib_bcd_converter.sv
// Iterative binary-to-packed-BCD converter for Fibonacci terms (double dabble).
// One term is accepted in IDLE, shifted DATA_W times in SHIFT, and held in DONE
// until the consumer takes it. Valid/ready on both sides; no overlap between terms.
// Optional build macro FIB_BCD_WRAP_DETECT_EN: flags a term smaller than the
// previously accepted one (8-bit sequence wrap). Without it, wrap is tied to 0.
module fib_bcd_converter
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W,
  parameter int DIGITS = FIB_BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  restart,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  wrap
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  fib_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  shift_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  // Per-digit add-3 correction applied to the BCD register before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    fib_bcd_digit_adj u_adj (
      .nib_i (bcd_q[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

`ifdef FIB_BCD_WRAP_DETECT_EN
  logic [DATA_W-1:0] prev_q;
  logic              wrap_q;

  // Wrap flag and previous-term tracking, updated only when a term is accepted.
  always_ff @(posedge clk) begin
    if (restart) begin
      prev_q <= '0;
      wrap_q <= 1'b0;
    end else if (state_q == ST_IDLE && in_valid) begin
      wrap_q <= (in_data < prev_q);
      prev_q <= in_data;
    end
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

  // Converter FSM with registered handshake outputs and the shift/BCD datapath.
  always_ff @(posedge clk) begin
    if (restart) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bcd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            shift_q    <= in_data;
            bcd_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Corrected digits and the binary operand shift as one long register.
          {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
          cnt_q            <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign bcd_out   = bcd_q;

endmodule : fib_bcd_converter

// File: tb/tb_fib_bcd_converter.sv
// Directed bench for fib_bcd_converter: reset state, conversions, latency,
// backpressure, mid-conversion restart and the Fibonacci wrap sequence.
module tb_fib_bcd_converter;
  import fib_pkg::*;

`ifdef FIB_BCD_WRAP_DETECT_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        restart;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  fib_bcd_t    bcd_out;
  logic        busy;
  logic        wrap;

  int checks;
  int errors;

  fib_bcd_converter #(.DATA_W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .busy      (busy),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Full handshake of one term with out_ready held high.
  task automatic convert(input logic [7:0] d, input logic [11:0] exp_bcd,
                         input bit wrap_if_en, input string tag);
    int lat;
    bit seen;
    out_ready = 1'b1;
    in_data   = d;
    in_valid  = 1'b1;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    in_data  = 8'h5A;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, lat, 32'd8);
    check({tag, "_bcd"}, {20'd0, bcd_out}, {20'd0, exp_bcd});
    check({tag, "_wrap"}, {31'd0, wrap}, {31'd0, WRAP_EN & wrap_if_en});
    step();
    check({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [7:0]  seq_d   [15];
  logic [11:0] seq_bcd [15];

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    restart   = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;

    // 1) Reset held three cycles
    repeat (3) step();
    restart = 1'b0;
    step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bcd", {20'd0, bcd_out}, 32'h000);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);

    // 2) 233 with immediate consumption
    convert(8'd233, 12'h233, 1'b0, "t233");

    // 3) Boundaries (0 after 233 is a wrap when enabled)
    convert(8'd0,   12'h000, 1'b1, "t0");
    convert(8'd255, 12'h255, 1'b0, "t255");

    // 4) Backpressure on 144 (144 after 255 wraps when enabled)
    out_ready = 1'b0;
    in_data   = 8'd144;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check("bp_latency", n, 32'd8);
    repeat (5) begin
      step();
      check("bp_bcd_hold", {20'd0, bcd_out}, 32'h144);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    check("bp_wrap", {31'd0, wrap}, {31'd0, WRAP_EN});
    out_ready = 1'b1;
    step();
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // 5) Restart on the 4th SHIFT cycle
    in_data  = 8'd200;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rs_out_valid", {31'd0, out_valid}, 32'd0);
    check("rs_in_ready", {31'd0, in_ready}, 32'd1);
    check("rs_bcd", {20'd0, bcd_out}, 32'h000);
    check("rs_busy", {31'd0, busy}, 32'd0);
    convert(8'd13, 12'h013, 1'b0, "t13");

    // 6) Generator sequence with wrap at 121
    restart = 1'b1;
    step();
    restart = 1'b0;
    seq_d   = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
    seq_bcd = '{12'h000, 12'h001, 12'h001, 12'h002, 12'h003, 12'h005, 12'h008, 12'h013,
                12'h021, 12'h034, 12'h055, 12'h089, 12'h144, 12'h233, 12'h121};
    for (int i = 0; i < 15; i++) begin
      convert(seq_d[i], seq_bcd[i], (i == 14), $sformatf("seq%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fib_bcd_converter
